axis_packet_tx: RTL
===================

# axis_packet_tx

Transmit-side AXI-Stream packet framer. Accepts a per-packet configuration `{k,len}` and an unframed payload byte stream, then emits exactly `len` beats with `m_axis_tlast` on the final beat. While the packet is on the wire, it drives a stable `packet_config` bus alongside. It sits upstream of the packet processing stage and supplies that stage's `s_axis_*` and `packet_config` inputs.

## Interface
- `Data_width`, 8: payload beat width; also the width of `k` and `len`.
- `Max_len`, 64: largest legal `len`; matches the downstream buffer `Depth`.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `cfg_k` in `Data_width`: offset field of the next packet.
- `cfg_len` in `Data_width`: beat count of the next packet.
- `cfg_valid` in 1: config offered.
- `cfg_ready` out 1: config accepted when `cfg_valid && cfg_ready`.
- `s_axis_tdata` in `Data_width`: raw payload.
- `s_axis_tvalid` in 1: payload beat offered.
- `s_axis_tready` out 1: payload beat accepted.
- `m_axis_tdata` out `Data_width`: framed payload.
- `m_axis_tvalid` out 1: output beat valid.
- `m_axis_tlast` out 1: final beat of packet.
- `m_axis_tready` in 1: downstream accept.
- `packet_config` out `2*Data_width`: `{k,len}` of the current packet, with `k` in the upper half.
- `pkt_count` out 16: number of completed packets; wraps modulo 2^16.
- `cfg_err` out 1: one-cycle pulse on rejection of an illegal config.
- `busy` out 1: high in SEND or DRAIN.

## Operation
- FSM states: IDLE, SEND, DRAIN.
- **IDLE**
  - `cfg_ready=1`.
  - On a config handshake with a legal config: latch `{cfg_k,cfg_len}` into `packet_config`, clear the beat counter, go to SEND.
  - A config is legal when `1 <= len <= Max_len` and `k < len`.
  - On a config handshake with an illegal config: the handshake still completes, `cfg_err` pulses for 1 cycle, the FSM stays in IDLE, and `packet_config` is unchanged.
- **SEND**
  - `cfg_ready=0`.
  - `s_axis_tready = !m_axis_tvalid || m_axis_tready`, giving a single registered output stage.
  - Each accepted input beat loads `m_axis_tdata`, sets `m_axis_tvalid`, and increments the beat counter.
  - `m_axis_tlast` is set on the beat where counter == `len-1`.
  - When that last beat is accepted, go to DRAIN.
- **DRAIN**
  - `s_axis_tready=0` and `cfg_ready=0`.
  - When the last output beat handshakes (`m_axis_tvalid && m_axis_tready && m_axis_tlast`), increment `pkt_count` and go to IDLE.
- Output register rules:
  - `m_axis_tvalid` clears on a handshake unless a new beat loads in the same cycle.
  - `m_axis_tdata` and `m_axis_tlast` hold stable while `m_axis_tvalid && !m_axis_tready`.
- `packet_config` is held from the config latch until after the tlast handshake. It never changes while any beat of the packet is pending.
- Beat counter width is `Data_width`. It never wraps, because `len <= Max_len < 2^Data_width`.
- Data passes through unmodified; no arithmetic is applied to the payload.

## Timing
- Reset state (asynchronous assert, synchronous release):
  - FSM = IDLE.
  - `cfg_ready=1`, `s_axis_tready=0`.
  - `m_axis_tvalid=0`, `m_axis_tlast=0`, `m_axis_tdata=0`.
  - `packet_config=0`, `pkt_count=0`, `cfg_err=0`, `busy=0`.
- Latencies:
  - Config handshake at cycle N: `busy=1` and `s_axis_tready=1` at N+1.
  - Input beat accepted at cycle N: appears on `m_axis` at N+1.
- Throughput: 1 beat/cycle with `m_axis_tready` held high.
- Packet gap: the minimum gap between packets is 2 cycles: the DRAIN to IDLE transition, then the config handshake.
- Simultaneous output handshake and input accept: the register reloads with no bubble.
- Reset asserted mid-packet: all state returns to reset values immediately. The partial packet is dropped, with no tlast emitted.
- `cfg_valid` asserted outside IDLE is ignored until IDLE.
- The `cfg_err` pulse is high in the cycle after the handshake.

## Test plan
- **Basic packet:** cfg `{k=2,len=4}`, 4 input beats 0x11..0x14, `m_axis_tready=1` -> output 0x11,0x12,0x13,0x14, tlast only on 0x14, `packet_config=0x0204` throughout, `pkt_count=1`.
- **Backpressure:** `len=3`, toggle `m_axis_tready` 1,0,0,1,… -> no beat lost or duplicated, data and tlast stable while stalled, `s_axis_tready=0` while the output register is full and stalled.
- **Illegal configs:** `{k=5,len=5}`, `{k=0,len=0}`, `{k=0,len=65}` -> `cfg_err` pulses 3 times, FSM stays IDLE, `packet_config` and `pkt_count` unchanged.
- **Back-to-back:** cfg `{0,1}` then `{1,64}` -> 1-beat packet with tlast on beat 0, then a 64-beat packet with tlast on beat 63; `packet_config` changes only after the first tlast handshake; `pkt_count=2`.
- **Reset mid-packet:** `len=8`, drive 3 beats, assert `rst` low -> all outputs are at reset values in the same cycle; after release, a new `{0,2}` packet frames correctly.
- **Counter wrap:** preload or run 65536 one-beat packets -> `pkt_count` wraps to 0.

Source files
------------

// File: rtl/axis_packet_tx.sv
// axis_packet_tx: frames a raw payload stream into len-beat AXI-Stream packets with tlast,
// driving a stable {k,len} packet_config while each packet is in flight.
module axis_packet_tx #(
    parameter int Data_width = 8,
    parameter int Max_len    = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [Data_width-1:0]   cfg_k,
    input  logic [Data_width-1:0]   cfg_len,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [Data_width-1:0]   s_axis_tdata,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    output logic [Data_width-1:0]   m_axis_tdata,
    output logic                    m_axis_tvalid,
    output logic                    m_axis_tlast,
    input  logic                    m_axis_tready,
    output logic [2*Data_width-1:0] packet_config,
    output logic [15:0]             pkt_count,
    output logic                    cfg_err,
    output logic                    busy
);
    typedef enum logic [1:0] {IDLE, SEND, DRAIN} state_t;
    localparam logic [Data_width-1:0] MAX_LEN_W = Data_width'(Max_len);
    state_t                  state_q, state_d;
    logic [Data_width-1:0]   cnt_q, cnt_d, tdata_q, tdata_d;
    logic                    tvalid_q, tvalid_d, tlast_q, tlast_d, cfg_err_q, cfg_err_d;
    logic [2*Data_width-1:0] pcfg_q, pcfg_d;
    logic [15:0]             pkt_count_q, pkt_count_d;
    logic                    cfg_legal, in_fire, out_fire, beat_last;
    assign cfg_ready     = state_q == IDLE;
    assign busy          = state_q != IDLE;
    assign s_axis_tready = (state_q == SEND) && (!tvalid_q || m_axis_tready);
    assign in_fire       = s_axis_tvalid && s_axis_tready;
    assign out_fire      = tvalid_q && m_axis_tready;
    assign beat_last     = cnt_q == pcfg_q[Data_width-1:0] - 1'b1;
    assign cfg_legal     = (cfg_len != '0) && (cfg_len <= MAX_LEN_W) && (cfg_k < cfg_len);
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign packet_config = pcfg_q;
    assign pkt_count     = pkt_count_q;
    assign cfg_err       = cfg_err_q;
    always_comb begin
        state_d     = state_q;
        cnt_d       = in_fire ? cnt_q + 1'b1 : cnt_q;
        tdata_d     = in_fire ? s_axis_tdata : tdata_q;
        tlast_d     = in_fire ? beat_last : tlast_q;
        tvalid_d    = in_fire || (tvalid_q && !out_fire);
        pcfg_d      = pcfg_q;
        pkt_count_d = pkt_count_q;
        cfg_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg_valid && cfg_legal) begin
                    pcfg_d  = {cfg_k, cfg_len};
                    cnt_d   = '0;
                    state_d = SEND;
                end
                cfg_err_d = cfg_valid && !cfg_legal;
            end
            SEND:  state_d = (in_fire && beat_last) ? DRAIN : SEND;
            DRAIN: begin
                // packet_config stays put until the final beat has actually left
                if (out_fire && tlast_q) begin
                    pkt_count_d = pkt_count_q + 16'd1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            pcfg_q      <= '0;
            pkt_count_q <= '0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tdata_q     <= tdata_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            pcfg_q      <= pcfg_d;
            pkt_count_q <= pkt_count_d;
            cfg_err_q   <= cfg_err_d;
        end
    end
endmodule
